// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake, holds the
// fetched instruction for the control unit and applies execute-stage redirects.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [6:0]  opcode,
  output logic        misaligned_fault
);

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [2:0] {StIdle, StReq, StDrain, StHold, StFault} state_e;

  state_e      r_state,         w_state_next;
  logic [31:0] r_pc,            w_pc_next;
  logic [31:0] r_imem_addr,     w_imem_addr_next;
  logic [31:0] r_instr,         w_instr_next;
  logic [31:0] r_instr_pc,      w_instr_pc_next;
  logic        r_fault_pending, w_fault_pending_next;
  logic        w_tgt_misaligned;

  assign w_tgt_misaligned = |redirect_target[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= StIdle;
      r_pc            <= RESET_PC;
      r_imem_addr     <= RESET_PC;
      r_instr         <= NopInstr;
      r_instr_pc      <= RESET_PC;
      r_fault_pending <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_pc            <= w_pc_next;
      r_imem_addr     <= w_imem_addr_next;
      r_instr         <= w_instr_next;
      r_instr_pc      <= w_instr_pc_next;
      r_fault_pending <= w_fault_pending_next;
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_pc_next            = r_pc;
    w_imem_addr_next     = r_imem_addr;
    w_instr_next         = r_instr;
    w_instr_pc_next      = r_instr_pc;
    w_fault_pending_next = r_fault_pending;

    unique case (r_state)
      StIdle: begin
        w_state_next     = StReq;
        w_imem_addr_next = r_pc;
      end

      StReq: begin
        if (redirect_valid) begin
          // Data acked alongside a redirect is on the wrong path and is dropped.
          w_pc_next            = redirect_target;
          w_fault_pending_next = w_tgt_misaligned;
          if (imem_ack) begin
            if (w_tgt_misaligned) begin
              w_state_next = StFault;
            end else begin
              w_state_next     = StReq;
              w_imem_addr_next = redirect_target;
            end
          end else begin
            w_state_next = StDrain;
          end
        end else if (imem_ack) begin
          w_instr_next    = imem_rdata;
          w_instr_pc_next = r_imem_addr;
          w_pc_next       = r_imem_addr + 32'd4;
          w_state_next    = StHold;
        end
      end

      StDrain: begin
        if (redirect_valid) begin
          w_pc_next            = redirect_target;
          w_fault_pending_next = w_tgt_misaligned;
        end
        // The latest redirect seen, including one in the ack cycle, decides the outcome.
        if (imem_ack) begin
          if (w_fault_pending_next) begin
            w_state_next = StFault;
          end else begin
            w_state_next     = StReq;
            w_imem_addr_next = w_pc_next;
          end
        end
      end

      StHold: begin
        if (redirect_valid) begin
          if (w_tgt_misaligned) begin
            w_state_next = StFault;
          end else begin
            w_pc_next        = redirect_target;
            w_imem_addr_next = redirect_target;
            w_state_next     = StReq;
          end
        end else if (!stall) begin
          w_state_next     = StReq;
          w_imem_addr_next = r_pc;
        end
      end

      StFault: begin
        w_state_next = StFault;
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign imem_req         = (r_state == StReq) || (r_state == StDrain);
  assign imem_addr        = r_imem_addr;
  assign instr            = r_instr;
  assign instr_pc         = r_instr_pc;
  assign instr_valid      = (r_state == StHold);
  assign opcode           = r_instr[6:0];
  assign misaligned_fault = (r_state == StFault);

endmodule
